// File: rtl/div_pkg.sv
// Shared types, constants and sign helpers for the sequential divider.
package div_pkg;

  localparam int unsigned DIV_XLEN  = 32;
  localparam int unsigned DIV_CNT_W = $clog2(DIV_XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Two's-complement negate when neg is set; also serves as abs() when the
  // caller passes the operand's sign bit as neg.
  function automatic logic [DIV_XLEN-1:0] div_neg_if(input logic [DIV_XLEN-1:0] x,
                                                     input logic                neg);
    return neg ? (~x + DIV_XLEN'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, WIDTH+1 cycles per op,
// with a combinational divide-by-zero bypass in IDLE.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             status,
  output logic             finished
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       r_state;
  div_state_t       w_state_nxt;
  logic             w_status_nxt;
  logic             w_finished_nxt;
  logic             r_status;
  logic             r_finished;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_q_res;
  logic [WIDTH-1:0] r_r_res;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_div_zero;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;
  logic             w_qbit;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;

  assign w_div_zero = (divisor == '0);
  assign w_accept   = (r_state == IDLE) && start && !w_div_zero;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_dvd_mag = WIDTH'(div_neg_if(DIV_XLEN'(dividend), signed_div & dividend[WIDTH-1]));
  assign w_dvs_mag = WIDTH'(div_neg_if(DIV_XLEN'(divisor),  signed_div & divisor[WIDTH-1]));

  // One restoring step: shift in the next dividend bit and try the subtract.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial   = w_shift - {1'b0, r_dvs};
  assign w_qbit    = ~w_trial[WIDTH];
  assign w_rem_nxt = w_qbit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};

  // Next-state and registered-flag decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_status_nxt   = 1'b0;
    w_finished_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt  = BUSY;
          w_status_nxt = 1'b1;
        end
      end
      BUSY: begin
        if (w_last) begin
          w_state_nxt    = DONE;
          w_finished_nxt = 1'b1;
        end else begin
          w_status_nxt = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and handshake flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_status   <= 1'b0;
      r_finished <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_status   <= w_status_nxt;
      r_finished <= w_finished_nxt;
    end
  end

  // Operand capture, iteration datapath and sign fix-up of the results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_q_res <= '0;
      r_r_res <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_neg_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      r_neg_r <= signed_div & dividend[WIDTH-1];
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      if (w_last) begin
        r_q_res <= WIDTH'(div_neg_if(DIV_XLEN'(w_quo_nxt), r_neg_q));
        r_r_res <= WIDTH'(div_neg_if(DIV_XLEN'(w_rem_nxt), r_neg_r));
      end
    end
  end

  // Zero-divisor bypass is visible only while IDLE.
  assign quotient  = ((r_state == IDLE) && w_div_zero) ? '1       : r_q_res;
  assign remainder = ((r_state == IDLE) && w_div_zero) ? dividend : r_r_res;
  assign status    = r_status;
  assign finished  = r_finished;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider serving the execute stage's divide request handshake (`start` / `status` / `finished`). It implements RISC-V M-extension DIV, DIVU, REM and REMU. The quotient and remainder come from one shared engine in 32+1 cycles. Divide-by-zero is resolved combinationally, so the requester never stalls on it.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (XLEN).

Ports:
- `clk` input 1: sole clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request. Held high by the requester every cycle until it sees `finished`.
- `signed_div` input 1: 1 = DIV/REM semantics, 0 = DIVU/REMU. Sampled with `start`.
- `dividend` input WIDTH: numerator. Sampled on accept.
- `divisor` input WIDTH: denominator. Sampled on accept; also used combinationally for the zero bypass.
- `quotient` output WIDTH: result quotient.
- `remainder` output WIDTH: result remainder.
- `status` output 1: busy; high in BUSY only.
- `finished` output 1: high for exactly one cycle (DONE). `quotient`/`remainder` are valid that cycle.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - `start`=1 and `divisor`≠0 → accept. Latch operands and `signed_div`, clear the iteration counter, go to BUSY.
  - `start`=1 and `divisor`=0 → no state change. `quotient`=all-ones and `remainder`=`dividend`, both combinational. `status`=0, `finished`=0.
- Accept:
  - Capture magnitudes: `abs(x)` when `signed_div`=1 and the MSB is set, otherwise `x` unchanged.
  - Capture `neg_q` = `signed_div` & (dividend MSB ^ divisor MSB).
  - Capture `neg_r` = `signed_div` & dividend MSB.
- BUSY: exactly WIDTH iterations, one per cycle, counter 0..WIDTH-1.
  - Shift the partial remainder left, bringing in the next dividend bit.
  - Compute trial = partial remainder − divisor magnitude (WIDTH+1 bits).
  - If trial is non-negative, keep it and set the quotient bit to 1; otherwise set the quotient bit to 0.
  - After the last iteration go to DONE. In the same edge, register the fixed-up results: quotient negated if `neg_q`, remainder negated if `neg_r`.
- DONE:
  - `finished`=1, `status`=0. Outputs show the registered results.
  - Unconditionally return to IDLE next cycle.
- Output mux: in IDLE with `divisor`=0 show the bypass values; otherwise show the result registers.
- Overflow (signed −2^WIDTH-1 / −1): no special case.
  - The magnitude 2^WIDTH-1 is representable unsigned and `neg_q`=0.
  - The result is quotient=0x80000000, remainder=0, matching RISC-V.
- Inputs are ignored in BUSY/DONE. Operand changes after accept do not affect the result.
- `start` still high in the IDLE cycle after DONE is treated as a new request. The requester must drop or replace it once it has consumed `finished`.

## Timing
- Reset values: state=IDLE, `status`=0, `finished`=0, counter=0, result registers=0. `quotient`/`remainder` therefore read 0 unless the zero bypass applies.
- Reset in any state, including mid-BUSY, aborts the operation. The block is IDLE the following cycle and produces no `finished`.
- Latency: `start` accepted in cycle N → `status`=1 in cycles N+1..N+WIDTH → `finished`=1 in cycle N+WIDTH+1 (N+33 for WIDTH=32).
- Requester stall equation it is built for: `stall = divisor≠0 & (status | (start & ~finished))`. This gives zero stall in DONE and in the zero-divisor case.
- Back-to-back: a new `start` in the cycle after DONE is accepted then. Throughput is one division per WIDTH+2 cycles.
- No combinational path from `start` to `finished`/`status`. The only input→output combinational path is the divisor-zero bypass.

## Structure
- `div_pkg`:
  - `div_state_t` enum {IDLE, BUSY, DONE}.
  - `DIV_XLEN`=32.
  - Counter width `$clog2(DIV_XLEN)`.
- Single module, no sub-modules. Magnitude/negate helpers are functions in `div_pkg`.

## Test plan
- Unsigned 100 / 7, `signed_div`=0, `start` held → `status` high 32 cycles, `finished` at cycle 33 with q=14, r=2. Next cycle IDLE with `finished`=0.
- Signed −7 / 2 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Signed 7 / −2 → q=−3, r=1.
- Divide by zero, dividend=0x12345678, both signed and unsigned → same cycle q=0xFFFFFFFF, r=0x12345678. `status`=0 and `finished`=0 throughout; state stays IDLE.
- Signed 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0. Unsigned 0xFFFFFFFF / 1 → q=0xFFFFFFFF, r=0.
- Assert `reset` in BUSY iteration 10 → `status`=0 next cycle, no `finished`. A subsequent 50/5 completes normally with q=10, r=0.
- Back-to-back: 9/4 then 1000/33 with `start` reasserted in the cycle after DONE → results (2,1) then (30,10), each exactly 33 cycles after its accept.
